// File: rtl/alu_pipe_if.sv
// Request/response bundle between an ALU requester and alu_pipe.
// master drives operations and consumes results; slave is the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             err;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, result_hi, carry, zero, overflow, err
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, result_hi, carry, zero, overflow, err
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle arithmetic/logic ops plus a WIDTH-cycle
// shift-add unsigned multiplier, with a one-deep registered result stage.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);
    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_carry;
    logic             r_zero;
    logic             r_overflow;
    logic             r_err;
    logic [W2-1:0]    r_acc;
    logic [W2-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;
    logic [W1-1:0]    w_add;
    logic [W1-1:0]    w_sub;
    logic [W1-1:0]    w_inc;
    logic [W1-1:0]    w_dec;
    logic [W2-1:0]    w_pp;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_z;
    logic             w_ov;
    logic             w_err;

    // in_ready is gated by rst_n so nothing is offered while held in reset
    assign w_in_ready = rst_n && ((r_state == S_IDLE) ||
                                  ((r_state == S_DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_mul   = (bus.sel == 4'd11);

    assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_inc = {1'b0, bus.a} + W1'(1);
    assign w_dec = {1'b0, bus.a} - W1'(1);
    assign w_pp  = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle datapath; the top bit of the WIDTH+1 sums is carry/borrow
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_ov  = 1'b0;
        w_err = 1'b0;
        case (bus.sel)
            4'd0: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_ov  = (bus.a[MSB] == bus.b[MSB]) && (w_add[MSB] != bus.a[MSB]);
            end
            4'd1: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_ov  = (bus.a[MSB] != bus.b[MSB]) && (w_sub[MSB] != bus.a[MSB]);
            end
            4'd2: w_res = bus.a & bus.b;
            4'd3: w_res = bus.a | bus.b;
            4'd4: w_res = bus.a ^ bus.b;
            4'd5: w_res = ~bus.a;
            4'd6: begin
                w_res = w_inc[WIDTH-1:0];
                w_c   = w_inc[WIDTH];
                w_ov  = ~bus.a[MSB] & w_inc[MSB];
            end
            4'd7: begin
                w_res = w_dec[WIDTH-1:0];
                w_c   = w_dec[WIDTH];
                w_ov  = bus.a[MSB] & ~w_dec[MSB];
            end
            4'd8: w_res = '0;
            4'd9: begin
                w_res = {bus.a[WIDTH-2:0], 1'b0};
                w_c   = bus.a[MSB];
            end
            4'd10: begin
                w_res = {1'b0, bus.a[WIDTH-1:1]};
                w_c   = bus.a[0];
            end
            4'd11: w_res = '0;
            default: w_err = 1'b1;
        endcase
        w_z = (bus.sel == 4'd8) ? (bus.a == bus.b) : (w_res == '0);
    end

    // Control FSM and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_acc    <= w_pp;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result    <= w_pp[WIDTH-1:0];
                        r_result_hi <= w_pp[W2-1:WIDTH];
                        r_zero      <= (w_pp == '0);
                        r_carry     <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_acc       <= '0;
                            r_mcand     <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier    <= bus.b;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_state     <= S_BUSY;
                        end else begin
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_carry     <= w_c;
                            r_zero      <= w_z;
                            r_overflow  <= w_ov;
                            r_err       <= w_err;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else if ((r_state == S_DONE) && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): vector table, scoreboard
// queue, and hand sequences for MUL latency, output stall and mid-op reset.
module tb_alu_pipe;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       ov;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        exp_t       e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t q[$];
    exp_t pend;
    logic accepted;
    logic rand_rdy;
    int   n_tests;
    int   n_fail;

    function automatic exp_t mk(input logic [7:0] res, input logic [7:0] hi,
                                input logic c, input logic z, input logic ov, input logic err);
        exp_t e;
        e.res = res; e.hi = hi; e.c = c; e.z = z; e.ov = ov; e.err = err;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                                 input exp_t e);
        vec_t v;
        v.a = a; v.b = b; v.sel = sel; v.e = e;
        return v;
    endfunction

    // Reference model built on integer arithmetic
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        exp_t e;
        int   sa, sb, s, t;
        e  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (sel)
            4'd0: begin s = int'(a) + int'(b); e.res = 8'(s); e.c = (s > 255);
                        t = sa + sb; e.ov = (t > 127) || (t < -128); end
            4'd1: begin s = int'(a) - int'(b); e.res = 8'(s); e.c = (a < b);
                        t = sa - sb; e.ov = (t > 127) || (t < -128); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~a;
            4'd6: begin s = int'(a) + 1; e.res = 8'(s); e.c = (s > 255); e.ov = (sa + 1 > 127); end
            4'd7: begin s = int'(a) - 1; e.res = 8'(s); e.c = (a == 8'd0); e.ov = (sa - 1 < -128); end
            4'd8: e.z = (a == b);
            4'd9: begin e.res = 8'(int'(a) * 2); e.c = a[7]; end
            4'd10: begin e.res = 8'(int'(a) / 2); e.c = a[0]; end
            4'd11: begin s = int'(a) * int'(b); e.res = 8'(s); e.hi = 8'(s / 256); end
            default: e.err = 1'b1;
        endcase
        if (sel != 4'd8) e.z = (e.res == 8'd0) && (e.hi == 8'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle: score any completed transfer, log any accept, advance an edge
    task automatic tick();
        exp_t got, e;
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got = {bus.result, bus.result_hi, bus.carry, bus.zero, bus.overflow, bus.err};
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL out: unexpected result res=%0h hi=%0h", bus.result, bus.result_hi);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL out: got res=%0h hi=%0h c=%0b z=%0b ov=%0b err=%0b expected res=%0h hi=%0h c=%0b z=%0b ov=%0b err=%0b",
                             got.res, got.hi, got.c, got.z, got.ov, got.err,
                             e.res, e.hi, e.c, e.z, e.ov, e.err);
                end
            end
        end
        accepted = rst_n && bus.in_valid && bus.in_ready;
        if (accepted) q.push_back(pend);
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] isel,
                         input exp_t e, output int tries);
        bus.in_valid = 1'b1;
        bus.a = ia; bus.b = ib; bus.sel = isel;
        pend = e;
        tries = 0;
        accepted = 1'b0;
        while (!accepted && tries < 50) begin
            tick();
            tries++;
        end
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept: got no accept after %0d cycles expected accept", tries);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) tick();
        check("drain", 32'(q.size()), 32'(0));
    endtask

    vec_t       tbl[20];
    int         tries;
    int         lat;
    logic       seen_valid;
    logic [7:0] ra, rb;
    logic [3:0] rs;

    initial begin
        n_tests = 0; n_fail = 0; rand_rdy = 1'b0; accepted = 1'b0; pend = '0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.out_ready = 1'b0;

        tbl[0]  = mkv(8'hFF, 8'h01, 4'd0,  mk(8'h00, 8'h00, 1, 1, 0, 0));
        tbl[1]  = mkv(8'h80, 8'h01, 4'd1,  mk(8'h7F, 8'h00, 0, 0, 1, 0));
        tbl[2]  = mkv(8'h01, 8'h02, 4'd1,  mk(8'hFF, 8'h00, 1, 0, 0, 0));
        tbl[3]  = mkv(8'hF0, 8'h3C, 4'd2,  mk(8'h30, 8'h00, 0, 0, 0, 0));
        tbl[4]  = mkv(8'h0F, 8'hF0, 4'd3,  mk(8'hFF, 8'h00, 0, 0, 0, 0));
        tbl[5]  = mkv(8'hAA, 8'hAA, 4'd4,  mk(8'h00, 8'h00, 0, 1, 0, 0));
        tbl[6]  = mkv(8'h0F, 8'h00, 4'd5,  mk(8'hF0, 8'h00, 0, 0, 0, 0));
        tbl[7]  = mkv(8'h7F, 8'h00, 4'd6,  mk(8'h80, 8'h00, 0, 0, 1, 0));
        tbl[8]  = mkv(8'h00, 8'h00, 4'd7,  mk(8'hFF, 8'h00, 1, 0, 0, 0));
        tbl[9]  = mkv(8'h5A, 8'h5A, 4'd8,  mk(8'h00, 8'h00, 0, 1, 0, 0));
        tbl[10] = mkv(8'h81, 8'h00, 4'd9,  mk(8'h02, 8'h00, 1, 0, 0, 0));
        tbl[11] = mkv(8'h81, 8'h00, 4'd10, mk(8'h40, 8'h00, 1, 0, 0, 0));
        tbl[12] = mkv(8'hFF, 8'hFF, 4'd11, mk(8'h01, 8'hFE, 0, 0, 0, 0));
        tbl[13] = mkv(8'h00, 8'h00, 4'd12, mk(8'h00, 8'h00, 0, 1, 0, 1));
        tbl[14] = mkv(8'h7F, 8'h01, 4'd0,  mk(8'h80, 8'h00, 0, 0, 1, 0));
        tbl[15] = mkv(8'h01, 8'h02, 4'd8,  mk(8'h00, 8'h00, 0, 0, 0, 0));
        tbl[16] = mkv(8'h00, 8'h37, 4'd11, mk(8'h00, 8'h00, 0, 1, 0, 0));
        tbl[17] = mkv(8'hFF, 8'h00, 4'd6,  mk(8'h00, 8'h00, 1, 1, 0, 0));
        tbl[18] = mkv(8'h80, 8'h00, 4'd7,  mk(8'h7F, 8'h00, 0, 0, 1, 0));
        tbl[19] = mkv(8'h12, 8'h34, 4'd15, mk(8'h00, 8'h00, 0, 1, 0, 1));

        // Reset values, asynchronous to clk
        #1 rst_n = 1'b0;
        #2;
        check("reset outputs", 32'({bus.out_valid, bus.result, bus.result_hi, bus.carry,
                                    bus.zero, bus.overflow, bus.err}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("in_ready after reset", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;

        // Vector table, back to back; non-MUL ops after non-MUL ops take one cycle each
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].e, tries);
            if (i > 0 && tbl[i-1].sel != 4'd11) check("throughput", 32'(tries), 32'(1));
        end
        drain();

        // MUL latency and in_ready low throughout BUSY, with a request held pending
        bus.in_valid = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.sel = 4'd11;
        pend = model(8'hFF, 8'hFF, 4'd11);
        accepted = 1'b0; tries = 0;
        while (!accepted && tries < 50) begin tick(); tries++; end
        check("mul accept", 32'(accepted), 32'(1));
        bus.a = 8'h01; bus.b = 8'h01; bus.sel = 4'd0;
        pend = model(8'h01, 8'h01, 4'd0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("busy ignores in_valid", 32'(accepted), 32'(0));
            if (bus.out_valid) begin lat = k; break; end
            check("busy in_ready", 32'(bus.in_ready), 32'(0));
        end
        bus.in_valid = 1'b0;
        check("mul latency", 32'(lat), 32'(8));
        drain();

        // Output stall: result held, in_ready low, pending request ignored
        bus.out_ready = 1'b0;
        issue(8'h12, 8'h34, 4'd0, model(8'h12, 8'h34, 4'd0), tries);
        bus.in_valid = 1'b1; bus.a = 8'hF0; bus.b = 8'hFF; bus.sel = 4'd4;
        pend = model(8'hF0, 8'hFF, 4'd4);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall hold", 32'({bus.out_valid, bus.result, bus.result_hi, bus.carry,
                                     bus.zero, bus.overflow, bus.err}),
                  32'({1'b1, 8'h46, 8'h00, 4'b0000}));
            check("stall in_ready", 32'(bus.in_ready), 32'(0));
            check("stall no accept", 32'(accepted), 32'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        check("accept on release", 32'(accepted), 32'(1));
        bus.in_valid = 1'b0;
        check("xor next edge", 32'({bus.out_valid, bus.result}), 32'({1'b1, 8'h0F}));
        drain();

        // Reset on the third BUSY cycle of a MUL abandons it
        issue(8'h13, 8'h11, 4'd11, model(8'h13, 8'h11, 4'd11), tries);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("reset mid mul", 32'({bus.out_valid, bus.result, bus.result_hi, bus.carry,
                                    bus.zero, bus.overflow, bus.err}), 32'(0));
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("in_ready after mid reset", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;
        seen_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("no stale out_valid", 32'(seen_valid), 32'(0));

        // Random ops with random consumer backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 4'($urandom_range(0, 15));
            issue(ra, rb, rs, model(ra, rb, rs), tries);
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
